// File: rtl/bus_snoop_responder_pkg.sv
// rtl/bus_snoop_responder_pkg.sv - shared types, snoop codes and result decode for the snoop responder
package bus_snoop_responder_pkg;

    typedef enum logic [2:0] {
        OP_READ       = 3'd1,
        OP_WRITE      = 3'd2,
        OP_INVALIDATE = 3'd3,
        OP_RWIM       = 3'd4
    } bus_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_WB
    } state_e;

    localparam logic [1:0] SNOOP_HIT   = 2'd0;
    localparam logic [1:0] SNOOP_HITM  = 2'd1;
    localparam logic [1:0] SNOOP_NOHIT = 2'd2;

    function automatic logic op_legal(input logic [2:0] op);
        return (op >= OP_READ) && (op <= OP_RWIM);
    endfunction

    // Base result comes from the low address bits; the op-based overrides are
    // applied afterwards in priority order.
    function automatic logic [1:0] snoop_result(input logic [2:0] op, input logic [1:0] lo);
        logic [1:0] r;
        case (lo)
            2'b00:   r = SNOOP_HIT;
            2'b01:   r = SNOOP_HITM;
            default: r = SNOOP_NOHIT;
        endcase
        if (!op_legal(op)) begin
            r = SNOOP_NOHIT;
        end else if (op == OP_WRITE) begin
            r = SNOOP_NOHIT;
        end else if ((op == OP_INVALIDATE) && (r == SNOOP_HITM)) begin
            r = SNOOP_HIT;
        end
        return r;
    endfunction

endpackage

// File: rtl/snoop_wb_burst.sv
// rtl/snoop_wb_burst.sv - modified-line writeback burst generator (beat counter, address, handshake)
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              one-cycle pulse that launches a burst at line_addr
//   line_addr          line-aligned base address of the burst
//   wb_valid/wb_ready  beat handshake
//   wb_addr, wb_last   current beat address and final-beat flag
//   done               high in the cycle the final beat is taken
module snoop_wb_burst #(
    parameter int ADDR_W     = 32,
    parameter int BEATS      = 8,
    parameter int BEAT_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] line_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_last,
    output logic              done
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [BW-1:0] beat_q;
    logic [BW-1:0] beat_nxt;

    assign beat_nxt = beat_q + 1'b1;
    assign done     = wb_valid && wb_ready && wb_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_last  <= 1'b0;
            beat_q   <= '0;
        end else if (start) begin
            wb_valid <= 1'b1;
            wb_addr  <= line_addr;
            wb_last  <= (LAST_BEAT == '0);
            beat_q   <= '0;
        end else if (wb_valid && wb_ready) begin
            if (wb_last) begin
                wb_valid <= 1'b0;
                wb_last  <= 1'b0;
                beat_q   <= '0;
            end else begin
                beat_q  <= beat_nxt;
                wb_addr <= wb_addr + ADDR_W'(BEAT_BYTES);
                // wb_last is precomputed so it stays a pure register output.
                wb_last <= (beat_nxt == LAST_BEAT);
            end
        end
    end

endmodule

// File: rtl/bus_snoop_responder.sv
// rtl/bus_snoop_responder.sv - snoop result responder with HITM writeback burst
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_ready      bus operation handshake; req_op, req_addr captured on acceptance
//   rsp_valid/rsp_ready      snoop result handshake; rsp_snoop 0 HIT, 1 HITM, 2 NOHIT
//   wb_valid/wb_ready        writeback beat handshake; wb_addr, wb_last per beat
//   op_err                   one-cycle pulse after an illegal op is accepted
//   hit_cnt/hitm_cnt/nohit_cnt  saturating counts of handshaked results
module bus_snoop_responder
    import bus_snoop_responder_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int BEAT_BYTES = 8,
    parameter int LAT        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_snoop,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_last,
    output logic              op_err,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       hitm_cnt,
    output logic [15:0]       nohit_cnt
);

    localparam int BEATS = LINE_BYTES / BEAT_BYTES;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        lat_q;
    logic              rsp_hs;
    logic              wb_start;
    logic              wb_done;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_hs    = (state_q == ST_RESP) && rsp_valid && rsp_ready;
    assign wb_start  = rsp_hs && (rsp_snoop == SNOOP_HITM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP: if (lat_q == 4'd0) state_d = ST_RESP;
            ST_RESP:   if (rsp_hs) state_d = (rsp_snoop == SNOOP_HITM) ? ST_WB : ST_IDLE;
            ST_WB:     if (wb_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            lat_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_snoop <= SNOOP_NOHIT;
            op_err    <= 1'b0;
            hit_cnt   <= '0;
            hitm_cnt  <= '0;
            nohit_cnt <= '0;
        end else begin
            op_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        // Loaded with LAT-1 so the result registers exactly LAT edges after acceptance.
                        lat_q  <= 4'(LAT - 1);
                        op_err <= !op_legal(req_op);
                    end
                end
                ST_LOOKUP: begin
                    if (lat_q == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_snoop <= snoop_result(op_q, addr_q[1:0]);
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                        case (rsp_snoop)
                            SNOOP_HIT:  if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                            SNOOP_HITM: if (hitm_cnt != 16'hFFFF) hitm_cnt <= hitm_cnt + 16'd1;
                            default:    if (nohit_cnt != 16'hFFFF) nohit_cnt <= nohit_cnt + 16'd1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    snoop_wb_burst #(
        .ADDR_W     (ADDR_W),
        .BEATS      (BEATS),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_wb_burst (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (wb_start),
        .line_addr (addr_q & ~LINE_MASK),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_last   (wb_last),
        .done      (wb_done)
    );

endmodule

// File: tb/tb_bus_snoop_responder.sv
// tb/tb_bus_snoop_responder.sv - directed self-checking bench for bus_snoop_responder
module tb_bus_snoop_responder;
    import bus_snoop_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_snoop;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_addr;
    logic        wb_last;
    logic        op_err;
    logic [15:0] hit_cnt, hitm_cnt, nohit_cnt;

    int errors = 0;
    int checks = 0;
    int exp_hit = 0, exp_hitm = 0, exp_nohit = 0;

    bus_snoop_responder #(
        .ADDR_W(32), .LINE_BYTES(64), .BEAT_BYTES(8), .LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_snoop(rsp_snoop),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_last(wb_last),
        .op_err(op_err), .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt), .nohit_cnt(nohit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and returns 1 time unit after its acceptance edge.
    task automatic accept(input logic [2:0] op, input logic [31:0] addr);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        req_op    = 3'd7;
        req_addr  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_snoop, wb_valid, wb_last, op_err} !== 7'b1_0_10_0_0_0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=1010000",
                     {req_ready, rsp_valid, rsp_snoop, wb_valid, wb_last, op_err});
        end
        checks++;
        if (wb_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_wb_addr got=%h required=0", wb_addr);
        end
        checks++;
        if ({hit_cnt, hitm_cnt, nohit_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters got=%h required=0", {hit_cnt, hitm_cnt, nohit_cnt});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_hit();
        rsp_ready = 1'b1;
        wb_ready  = 1'b1;
        accept(OP_READ, 32'h0000_1000);
        checks++;
        if ({req_ready, op_err} !== 2'b00) begin
            errors++;
            $display("FAIL read_after_accept got={req_ready,op_err}=%b required=00", {req_ready, op_err});
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_early_rsp rsp_valid=%b required=0 at k+1", rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_snoop} !== 3'b1_00) begin
            errors++;
            $display("FAIL read_rsp got={valid,snoop}=%b required=100 at k+2", {rsp_valid, rsp_snoop});
        end
        tick();
        exp_hit++;
        checks++;
        if ({rsp_valid, req_ready, wb_valid} !== 3'b010) begin
            errors++;
            $display("FAIL read_after_hs got={rsp_valid,req_ready,wb_valid}=%b required=010",
                     {rsp_valid, req_ready, wb_valid});
        end
        checks++;
        if (hit_cnt !== 16'(exp_hit)) begin
            errors++;
            $display("FAIL read_hit_cnt got=%0d required=%0d", hit_cnt, exp_hit);
        end
    endtask

    task automatic test_rwim_burst();
        rsp_ready = 1'b1;
        wb_ready  = 1'b1;
        accept(OP_RWIM, 32'h0000_1041);
        wait_rsp();
        checks++;
        if (rsp_snoop !== SNOOP_HITM) begin
            errors++;
            $display("FAIL rwim_snoop got=%0d required=1", rsp_snoop);
        end
        tick();
        exp_hitm++;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if ({wb_valid, wb_addr, wb_last} !== {1'b1, 32'h1040 + 32'(8 * b), b == 7}) begin
                errors++;
                $display("FAIL rwim_beat%0d got valid=%b addr=%h last=%b required valid=1 addr=%h last=%b",
                         b, wb_valid, wb_addr, wb_last, 32'h1040 + 32'(8 * b), b == 7);
            end
            tick();
        end
        checks++;
        if ({wb_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rwim_end got={wb_valid,req_ready}=%b required=01", {wb_valid, req_ready});
        end
        checks++;
        if (hitm_cnt !== 16'(exp_hitm)) begin
            errors++;
            $display("FAIL rwim_hitm_cnt got=%0d required=%0d", hitm_cnt, exp_hitm);
        end
    endtask

    task automatic test_burst_stall();
        int nbeat = 0;
        rsp_ready = 1'b1;
        accept(OP_READ, 32'h0000_2081);
        wait_rsp();
        checks++;
        if (rsp_snoop !== SNOOP_HITM) begin
            errors++;
            $display("FAIL stall_snoop got=%0d required=1", rsp_snoop);
        end
        tick();
        exp_hitm++;
        for (int cyc = 0; cyc < 64 && nbeat < 8; cyc++) begin
            wb_ready = (cyc % 2 == 1);
            checks++;
            if ({wb_valid, wb_addr, wb_last} !== {1'b1, 32'h2080 + 32'(8 * nbeat), nbeat == 7}) begin
                errors++;
                $display("FAIL stall_beat%0d cyc%0d got valid=%b addr=%h last=%b required valid=1 addr=%h last=%b",
                         nbeat, cyc, wb_valid, wb_addr, wb_last, 32'h2080 + 32'(8 * nbeat), nbeat == 7);
            end
            if (wb_valid && wb_ready) nbeat++;
            tick();
        end
        wb_ready = 1'b1;
        checks++;
        if (nbeat !== 8) begin
            errors++;
            $display("FAIL stall_beat_count got=%0d required=8", nbeat);
        end
        tick();
        checks++;
        if ({wb_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_no_dup got={wb_valid,req_ready}=%b required=01", {wb_valid, req_ready});
        end
        checks++;
        if (hitm_cnt !== 16'(exp_hitm)) begin
            errors++;
            $display("FAIL stall_hitm_cnt got=%0d required=%0d", hitm_cnt, exp_hitm);
        end
    endtask

    task automatic test_overrides();
        logic [2:0]  ops   [5] = '{OP_WRITE, OP_INVALIDATE, 3'd7, OP_RWIM, OP_READ};
        logic [31:0] addrs [5] = '{32'h0000_5001, 32'h0000_5101, 32'h0000_5201, 32'h0000_5302, 32'h0000_5403};
        logic [1:0]  exps  [5] = '{SNOOP_NOHIT, SNOOP_HIT, SNOOP_NOHIT, SNOOP_NOHIT, SNOOP_NOHIT};
        logic        errs  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rsp_ready = 1'b1;
        wb_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept(ops[i], addrs[i]);
            checks++;
            if (op_err !== errs[i]) begin
                errors++;
                $display("FAIL ovr%0d_op_err got=%b required=%b", i, op_err, errs[i]);
            end
            tick();
            checks++;
            if (op_err !== 1'b0) begin
                errors++;
                $display("FAIL ovr%0d_op_err_pulse got=%b required=0", i, op_err);
            end
            wait_rsp();
            checks++;
            if (rsp_snoop !== exps[i]) begin
                errors++;
                $display("FAIL ovr%0d_snoop got=%0d required=%0d", i, rsp_snoop, exps[i]);
            end
            if (exps[i] == SNOOP_HIT) exp_hit++;
            else exp_nohit++;
            tick();
            checks++;
            if ({wb_valid, req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL ovr%0d_no_burst got={wb_valid,req_ready}=%b required=01", i, {wb_valid, req_ready});
            end
        end
        checks++;
        if ({hit_cnt, hitm_cnt, nohit_cnt} !== {16'(exp_hit), 16'(exp_hitm), 16'(exp_nohit)}) begin
            errors++;
            $display("FAIL ovr_counters got=%0d/%0d/%0d required=%0d/%0d/%0d",
                     hit_cnt, hitm_cnt, nohit_cnt, exp_hit, exp_hitm, exp_nohit);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        accept(OP_READ, 32'h0000_3000);
        req_valid = 1'b1;
        req_op    = OP_WRITE;
        req_addr  = 32'h0000_3001;
        wait_rsp();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({req_ready, rsp_valid, rsp_snoop} !== 4'b0_1_00) begin
                errors++;
                $display("FAIL b2b_hold%0d got={req_ready,rsp_valid,snoop}=%b required=0100",
                         c, {req_ready, rsp_valid, rsp_snoop});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        exp_hit++;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_after_hs got={req_ready,rsp_valid}=%b required=10", {req_ready, rsp_valid});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept req_ready=%b required=0", req_ready);
        end
        wait_rsp();
        checks++;
        if (rsp_snoop !== SNOOP_NOHIT) begin
            errors++;
            $display("FAIL b2b_second_snoop got=%0d required=2", rsp_snoop);
        end
        exp_nohit++;
        tick();
        checks++;
        if ({hit_cnt, nohit_cnt} !== {16'(exp_hit), 16'(exp_nohit)}) begin
            errors++;
            $display("FAIL b2b_counters got=%0d/%0d required=%0d/%0d", hit_cnt, nohit_cnt, exp_hit, exp_nohit);
        end
    endtask

    task automatic test_reset_mid_burst();
        rsp_ready = 1'b1;
        wb_ready  = 1'b1;
        accept(OP_RWIM, 32'h0000_1041);
        wait_rsp();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if ({wb_valid, wb_addr} !== {1'b1, 32'h0000_1058}) begin
            errors++;
            $display("FAIL rst_beat3 got valid=%b addr=%h required valid=1 addr=00001058", wb_valid, wb_addr);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_snoop, wb_valid, wb_last, op_err} !== 7'b1_0_10_0_0_0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got=%b required=1010000",
                     {req_ready, rsp_valid, rsp_snoop, wb_valid, wb_last, op_err});
        end
        checks++;
        if (wb_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_wb_addr got=%h required=0", wb_addr);
        end
        checks++;
        if ({hit_cnt, hitm_cnt, nohit_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL rst_mid_counters got=%h required=0", {hit_cnt, hitm_cnt, nohit_cnt});
        end
        rst_n = 1'b1;
        exp_hit = 0;
        exp_hitm = 0;
        exp_nohit = 0;
        tick();
        tick();
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_more_beats wb_valid=%b required=0", wb_valid);
        end
        accept(OP_READ, 32'h0000_4000);
        wait_rsp();
        checks++;
        if (rsp_snoop !== SNOOP_HIT) begin
            errors++;
            $display("FAIL rst_read_snoop got=%0d required=0", rsp_snoop);
        end
        tick();
        exp_hit++;
        checks++;
        if ({hit_cnt, hitm_cnt, wb_valid} !== {16'(exp_hit), 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_read_result got hit=%0d hitm=%0d wb_valid=%b required hit=1 hitm=0 wb_valid=0",
                     hit_cnt, hitm_cnt, wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_rwim_burst();
        test_burst_stall();
        test_overrides();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t required=finish before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
